// File: rtl/seq_encoder_8to3_if.sv
// Request-vector / encoded-index handshake bundle for seq_encoder_8to3.
// slave is the encoder side, master is the producer/consumer side.
interface seq_encoder_8to3_if;
   logic       req_valid;
   logic [7:0] req_in;
   logic       req_ready;
   logic       idx_valid;
   logic [2:0] idx;
   logic       idx_ready;
   logic [7:0] pending;
   logic       done;
   logic       zero_req;

   modport slave (
      input  req_valid, req_in, idx_ready,
      output req_ready, idx_valid, idx, pending, done, zero_req
   );

   modport master (
      output req_valid, req_in, idx_ready,
      input  req_ready, idx_valid, idx, pending, done, zero_req
   );
endinterface

// File: rtl/seq_encoder_8to3.sv
// Sequential multi-hot to binary encoder: takes an 8-bit vector and
// emits the index of every set bit, one per handshake, in priority order.
module seq_encoder_8to3 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   seq_encoder_8to3_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pending_q, pending_d;
   logic       done_q, done_d;
   logic       zero_req_q, zero_req_d;

   logic [2:0] idx_sel;
   logic [7:0] cleared;

   // The last match in scan order wins, giving the priority bit.
   always_comb begin
      idx_sel = 3'd0;
      if (LSB_FIRST) begin
         for (int i = 7; i >= 0; i--)
            if (pending_q[i]) idx_sel = 3'(i);
      end else begin
         for (int i = 0; i < 8; i++)
            if (pending_q[i]) idx_sel = 3'(i);
      end
   end

   assign cleared = pending_q & ~(8'd1 << idx_sel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= 8'h00;
         done_q     <= 1'b0;
         zero_req_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         done_q     <= done_d;
         zero_req_q <= zero_req_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      done_d     = 1'b0;
      zero_req_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               pending_d = bus.req_in;
               if (bus.req_in != 8'h00) state_d = SERVE;
               else zero_req_d = 1'b1;
            end
         end
         SERVE: begin
            if (bus.idx_ready) begin
               pending_d = cleared;
               if (cleared == 8'h00) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = 8'h00;
         end
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.idx_valid = (state_q == SERVE);
      bus.idx       = (state_q == SERVE) ? idx_sel : 3'd0;
      bus.pending   = pending_q;
      bus.done      = done_q;
      bus.zero_req  = zero_req_q;
   end

endmodule

// File: tb/tb_seq_encoder_8to3.sv
// Directed bench for seq_encoder_8to3, both priority orders.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_seq_encoder_8to3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_encoder_8to3_if if0 ();
   seq_encoder_8to3_if if1 ();

   seq_encoder_8to3 #(.LSB_FIRST(1'b1)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   seq_encoder_8to3 #(.LSB_FIRST(1'b0)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   int exp_lsb [3];
   int exp_msb [3];
   int n;
   logic [7:0] pm;
   logic rdy;

   initial begin
      exp_lsb = '{1, 4, 7};
      exp_msb = '{7, 4, 1};
      if0.req_valid = 0; if0.req_in = 0; if0.idx_ready = 0;
      if1.req_valid = 0; if1.req_in = 0; if1.idx_ready = 0;
      tick; tick;
      chk("rst_pending", if0.pending, 0);
      chk("rst_idx_valid", if0.idx_valid, 0);
      chk("rst_idx", if0.idx, 0);
      chk("rst_req_ready", if0.req_ready, 1);
      chk("rst_done", if0.done, 0);
      chk("rst_zero", if0.zero_req, 0);
      rst = 0;
      tick;

      // single bit
      if0.req_valid = 1; if0.req_in = 8'h04;
      tick;
      if0.req_valid = 0;
      chk("one_valid", if0.idx_valid, 1);
      chk("one_idx", if0.idx, 2);
      chk("one_pending", if0.pending, 8'h04);
      chk("one_ready", if0.req_ready, 0);
      if0.idx_ready = 1;
      tick;
      if0.idx_ready = 0;
      chk("one_done", if0.done, 1);
      chk("one_pend0", if0.pending, 0);
      chk("one_rdy1", if0.req_ready, 1);
      chk("one_ivld0", if0.idx_valid, 0);
      tick;
      chk("one_done_pulse", if0.done, 0);

      // 8'b10010010 in both priority orders
      if0.req_valid = 1; if0.req_in = 8'h92; if0.idx_ready = 1;
      if1.req_valid = 1; if1.req_in = 8'h92; if1.idx_ready = 1;
      tick;
      if0.req_valid = 0; if1.req_valid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("seq_lsb", if0.idx, exp_lsb[i]);
         chk("seq_msb", if1.idx, exp_msb[i]);
         chk("seq_done_early", if0.done, 0);
         tick;
      end
      chk("seq_lsb_done", if0.done, 1);
      chk("seq_msb_done", if1.done, 1);
      chk("seq_ivld0", if0.idx_valid, 0);
      if0.idx_ready = 0; if1.idx_ready = 0;
      tick;

      // 8'hFF with stalls
      if0.req_valid = 1; if0.req_in = 8'hFF;
      tick;
      if0.req_valid = 0;
      n = 0;
      pm = 8'hFF;
      for (int c = 0; c < 40 && n < 8; c++) begin
         rdy = (c % 3 == 0);
         if0.idx_ready = rdy;
         chk("ff_valid", if0.idx_valid, 1);
         chk("ff_idx", if0.idx, n);
         chk("ff_pending", if0.pending, pm);
         chk("ff_ready", if0.req_ready, 0);
         tick;
         if (rdy) begin
            pm[n[2:0]] = 1'b0;
            n++;
         end
      end
      if0.idx_ready = 0;
      chk("ff_count", n, 8);
      chk("ff_done", if0.done, 1);
      tick;
      chk("ff_done_pulse", if0.done, 0);

      // all-zero vector
      if0.req_valid = 1; if0.req_in = 8'h00;
      tick;
      if0.req_valid = 0;
      chk("zero_pulse", if0.zero_req, 1);
      chk("zero_ivld", if0.idx_valid, 0);
      chk("zero_rdy", if0.req_ready, 1);
      chk("zero_nodone", if0.done, 0);
      tick;
      chk("zero_pulse_end", if0.zero_req, 0);
      chk("zero_rdy2", if0.req_ready, 1);

      // new vector ignored during SERVE
      if0.req_valid = 1; if0.req_in = 8'h60;
      tick;
      if0.req_in = 8'h01;
      tick;
      chk("ign_pending", if0.pending, 8'h60);
      chk("ign_idx", if0.idx, 5);
      chk("ign_ready", if0.req_ready, 0);
      if0.idx_ready = 1;
      tick;
      chk("ign_pending2", if0.pending, 8'h40);
      chk("ign_idx2", if0.idx, 6);
      if0.req_valid = 0;
      tick;
      if0.idx_ready = 0;
      chk("ign_done", if0.done, 1);
      tick;

      // asynchronous reset mid-vector
      if0.req_valid = 1; if0.req_in = 8'h0C;
      tick;
      if0.req_valid = 0;
      chk("ar_idx", if0.idx, 2);
      #2 rst = 1;
      #1;
      chk("ar_pending", if0.pending, 0);
      chk("ar_ivld", if0.idx_valid, 0);
      chk("ar_rdy", if0.req_ready, 1);
      chk("ar_done", if0.done, 0);
      tick;
      rst = 0;
      tick;
      chk("ar_done_after", if0.done, 0);
      if0.req_valid = 1; if0.req_in = 8'h80;
      tick;
      if0.req_valid = 0;
      chk("ar_new_idx", if0.idx, 7);
      if0.idx_ready = 1;
      tick;
      if0.idx_ready = 0;
      chk("ar_new_done", if0.done, 1);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
